tc_dwell_timer: RTL and testbench

Runtime-loadable interval timer built on the team's terminal-count scheme. It counts down instead of up and detects terminal count from the counter MSB (borrow) rather than a wide compare, so the carry chain stays short at any width. Downstream blocks use it for programmable dwell, holdoff and periodic-strobe generation. Counter width comes from `tc::tcbits(MAX_COUNT)`.

---
 rtl/tc_dwell_timer.sv | 111 +++++++++++
 tb/tb_tc_dwell_timer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_dwell_timer.sv
// Runtime-loadable down-counting interval timer; terminal count is taken from the
// counter sign bit so no wide comparator sits on the critical path.
module tc_dwell_timer #(
    parameter int unsigned MAX_COUNT = 1024,
    // Same value as tc::tcbits(MAX_COUNT); derived, do not override
    parameter int unsigned CW        = $clog2(MAX_COUNT) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [CW-1:0] count_i,
    input  logic          start_i,
    input  logic          reload_i,
    input  logic          abort_i,
    output logic          ready_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [CW-1:0] remaining_o
);

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    localparam logic [CW-1:0]        MaxCnt = CW'(MAX_COUNT);
    localparam logic [CW-1:0]        MinCnt = CW'(1);
    localparam logic signed [CW-1:0] One    = CW'(1);
    localparam logic signed [CW-1:0] Two    = CW'(2);

    state_e                state_q, state_d;
    logic signed [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]         period_q, period_d;
    logic                  done_q, done_d;
    logic [CW-1:0]         rem_q, rem_d;
    logic [CW-1:0]         n_norm;
    logic                  tc;

    always_comb begin
        if (count_i == '0) begin
            n_norm = MinCnt;
        end else if (count_i > MaxCnt) begin
            n_norm = MaxCnt;
        end else begin
            n_norm = count_i;
        end
    end

    // Counter goes negative exactly on the last busy cycle.
    assign tc = (state_q == StRun) && cnt_q[CW-1];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d  = StRun;
                    cnt_d    = $signed(n_norm) - Two;
                    period_d = n_norm;
                end
            end
            StRun: begin
                if (abort_i) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (tc) begin
                    done_d = 1'b1;
                    if (reload_i) begin
                        cnt_d = $signed(period_q) - Two;
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - One;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        rem_d = (state_d == StRun) ? $unsigned(cnt_d + One) : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            period_q <= '0;
            done_q   <= 1'b0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            done_q   <= done_d;
            rem_q    <= rem_d;
        end
    end

    assign busy_o      = (state_q == StRun);
    assign done_o      = done_q;
    assign remaining_o = rem_q;
    assign ready_o     = !busy_o && !rst_i;

endmodule

// File: tb/tb_tc_dwell_timer.sv
// Self-checking bench for tc_dwell_timer: deadline-based reference model compared every
// cycle, directed scenarios with literal latencies, then a randomized soak.
module tb_tc_dwell_timer;

    localparam int unsigned MAX_COUNT = 1024;
    localparam int unsigned CW        = $clog2(MAX_COUNT) + 1;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic          reload_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [CW-1:0] count_i = '0;
    logic          ready_o, busy_o, done_o;
    logic [CW-1:0] remaining_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tc_dwell_timer #(
        .MAX_COUNT(MAX_COUNT)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .count_i    (count_i),
        .start_i    (start_i),
        .reload_i   (reload_i),
        .abort_i    (abort_i),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .remaining_o(remaining_o)
    );

    // Reference model: an interval is an absolute deadline edge, not a counter.
    int edge_no    = 0;
    bit m_busy     = 1'b0;
    bit m_done     = 1'b0;
    int m_deadline = 0;
    int m_period   = 0;

    function automatic int norm(input int n);
        if (n == 0) return 1;
        if (n > int'(MAX_COUNT)) return int'(MAX_COUNT);
        return n;
    endfunction

    always @(posedge clk) begin
        edge_no++;
        m_done = 1'b0;
        if (rst_i) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (abort_i) begin
                m_busy = 1'b0;
            end else if (edge_no == m_deadline) begin
                m_done = 1'b1;
                if (reload_i) m_deadline += m_period;
                else m_busy = 1'b0;
            end
        end else if (start_i) begin
            m_period   = norm(int'(count_i));
            m_deadline = edge_no + m_period;
            m_busy     = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    always @(negedge clk) begin
        if (edge_no >= 1) begin
            check("busy", 32'(busy_o), 32'(m_busy));
            check("done", 32'(done_o), 32'(m_done));
            check("remaining", 32'(remaining_o), m_busy ? 32'(m_deadline - edge_no - 1) : 32'd0);
            check("ready", 32'(ready_o), 32'(!m_busy && !rst_i));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic start(input int n, input bit rel, output int t0);
        count_i  = CW'(n);
        reload_i = rel;
        start_i  = 1'b1;
        cycle();
        start_i = 1'b0;
        t0      = edge_no;
    endtask

    // Returns the edge after which done_o was seen, or -1 when the budget expires.
    task automatic wait_done(input int budget, output int e);
        e = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                e = edge_no;
                return;
            end
        end
    endtask

    task automatic count_dones(input int ncyc, output int cnt);
        cnt = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) cnt++;
        end
    endtask

    initial begin
        int t0, e, e2, n;

        // Reset
        cycle();
        cycle();
        @(negedge clk);
        check("rst_ready_low", 32'(ready_o), 32'd0);
        check("rst_busy_low", 32'(busy_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk);
        check("ready_after_release", 32'(ready_o), 32'd1);

        // Single shot N=5
        start(5, 1'b0, t0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("ss_remaining", 32'(remaining_o), 32'(4 - k));
            check("ss_busy", 32'(busy_o), 32'd1);
        end
        @(negedge clk);
        check("ss_done", 32'(done_o), 32'd1);
        check("ss_done_ready", 32'(ready_o), 32'd1);
        check("ss_done_edge", 32'(edge_no - t0), 32'd5);

        // Edge counts
        start(1, 1'b0, t0);
        wait_done(20, e);
        check("n1_latency", 32'(e - t0), 32'd1);
        start(0, 1'b0, t0);
        wait_done(20, e);
        check("n0_latency", 32'(e - t0), 32'd1);
        start(2000, 1'b0, t0);
        wait_done(1100, e);
        check("sat_latency", 32'(e - t0), 32'd1024);

        // Periodic N=3, reload dropped before the third terminal
        start(3, 1'b1, t0);
        wait_done(20, e);
        check("per_1", 32'(e - t0), 32'd3);
        wait_done(20, e);
        check("per_2", 32'(e - t0), 32'd6);
        reload_i = 1'b0;
        wait_done(20, e);
        check("per_3", 32'(e - t0), 32'd9);
        count_dones(12, n);
        check("per_no_more", 32'(n), 32'd0);

        // Start during a run is ignored
        start(10, 1'b0, t0);
        cycle();
        count_i = CW'(7);
        start_i = 1'b1;
        cycle();
        start_i = 1'b0;
        wait_done(30, e);
        check("ignored_start", 32'(e - t0), 32'd10);
        count_dones(12, n);
        check("ignored_not_queued", 32'(n), 32'd0);

        // Back-to-back: start in the done cycle
        start(4, 1'b0, t0);
        wait_done(20, e);
        start(6, 1'b0, t0);
        check("b2b_accept_edge", 32'(t0 - e), 32'd1);
        wait_done(20, e2);
        check("b2b_latency", 32'(e2 - t0), 32'd6);

        // Abort mid-run
        start(8, 1'b0, t0);
        cycle();
        cycle();
        abort_i = 1'b1;
        cycle();
        abort_i = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy_o), 32'd0);
        count_dones(12, n);
        check("abort_no_done", 32'(n), 32'd0);

        // Abort on the terminal cycle
        start(4, 1'b0, t0);
        cycle();
        cycle();
        cycle();
        abort_i = 1'b1;
        cycle();
        abort_i = 1'b0;
        count_dones(10, n);
        check("abort_tc_no_done", 32'(n), 32'd0);

        // Reset mid-run
        start(6, 1'b0, t0);
        cycle();
        cycle();
        cycle();
        rst_i = 1'b1;
        cycle();
        @(negedge clk);
        check("mr_busy", 32'(busy_o), 32'd0);
        check("mr_ready", 32'(ready_o), 32'd0);
        check("mr_remaining", 32'(remaining_o), 32'd0);
        cycle();
        cycle();
        rst_i = 1'b0;
        @(negedge clk);
        check("mr_ready_release", 32'(ready_o), 32'd1);
        check("mr_no_done", 32'(done_o), 32'd0);
        start(2, 1'b0, t0);
        wait_done(20, e);
        check("mr_fresh", 32'(e - t0), 32'd2);

        // Randomized soak against the model
        for (int i = 0; i < 4000; i++) begin
            rst_i    = ($urandom_range(0, 299) == 0);
            start_i  = ($urandom_range(0, 3) == 0);
            reload_i = ($urandom_range(0, 2) != 0);
            abort_i  = ($urandom_range(0, 39) == 0);
            count_i  = ($urandom_range(0, 15) == 0) ? CW'($urandom_range(0, 2047))
                                                     : CW'($urandom_range(0, 12));
            cycle();
        end
        rst_i    = 1'b0;
        start_i  = 1'b0;
        abort_i  = 1'b0;
        reload_i = 1'b0;
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
